// File: rtl/instr_encoder_loader_if.sv
// Instruction-beat handshake and program-memory write port shared by the
// encoder (slave) and whatever feeds it and owns the memory (master).
interface instr_encoder_loader_if #(
  parameter int REG_W   = 4,
  parameter int IMM_W   = 8,
  parameter int PC_W    = 10,
  parameter int INSTR_W = 6 + 3*REG_W
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_kind;
  logic [2:0]         in_sub;
  logic [REG_W-1:0]   in_ra;
  logic [REG_W-1:0]   in_rb;
  logic [REG_W-1:0]   in_rd;
  logic [IMM_W-1:0]   in_imm;
  logic [PC_W-1:0]    in_addr;
  logic               mem_we;
  logic [PC_W-1:0]    mem_addr;
  logic [INSTR_W-1:0] mem_wdata;

  modport master (
    output in_valid, in_kind, in_sub, in_ra, in_rb, in_rd, in_imm, in_addr,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_sub, in_ra, in_rb, in_rd, in_imm, in_addr,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs symbolic instructions into control-unit instruction words and streams
// them into program memory, closing each program with a self-jump halt word.
module instr_encoder_loader #(
  parameter int REG_W   = 4,
  parameter int IMM_W   = 8,
  parameter int PC_W    = 10,
  parameter int INSTR_W = 6 + 3*REG_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 finish,
  instr_encoder_loader_if.slave bus,
  output logic [PC_W:0]        count,
  output logic                 err,
  output logic                 done
);
  localparam int L_W = 3*REG_W;
  // Last slot is kept free so the halt word always fits.
  localparam logic [PC_W-1:0] PTR_MAX = '1;

  typedef enum logic [1:0] {IDLE, LOAD, SEAL, DONE} state_t;

  state_t             state;
  logic [PC_W-1:0]    ptr;
  logic [PC_W-1:0]    ptr_inc;
  logic               accept;
  logic               enc_ok;
  logic [INSTR_W-1:0] enc_word;
  logic [INSTR_W-1:0] halt_word;
  logic [IMM_W-1:0]   imm;

  assign imm       = bus.in_imm;
  assign ptr_inc   = ptr + 1'b1;
  assign accept    = bus.in_valid && bus.in_ready;
  assign halt_word = {6'b111100, L_W'(ptr)};

  // Opcode layout mirrors the control unit's decoder table.
  always_comb begin
    enc_ok   = 1'b0;
    enc_word = '0;
    case (bus.in_kind)
      2'd0: begin
        enc_ok   = 1'b1;
        enc_word = {1'b0, bus.in_sub, 2'b00, bus.in_ra, bus.in_rb, bus.in_rd};
      end
      2'd1: begin
        enc_ok   = ~bus.in_sub[2];
        enc_word = {2'b10, bus.in_sub[1:0], 2'b00, imm, bus.in_rd};
      end
      2'd2: begin
        enc_ok   = (bus.in_sub <= 3'd2);
        enc_word = {4'b1111, bus.in_sub[1:0], L_W'(bus.in_addr)};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      ptr           <= '0;
      count         <= '0;
      err           <= 1'b0;
      done          <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (start) begin
        // Restart wins over finish and over any beat in the same cycle.
        state        <= LOAD;
        ptr          <= '0;
        count        <= '0;
        err          <= 1'b0;
        done         <= 1'b0;
        bus.in_ready <= 1'b1;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            if (accept) begin
              if (enc_ok) begin
                bus.mem_we    <= 1'b1;
                bus.mem_addr  <= ptr;
                bus.mem_wdata <= enc_word;
                ptr           <= ptr_inc;
                count         <= count + 1'b1;
              end else begin
                err <= 1'b1;
              end
            end
            if (finish) begin
              state        <= SEAL;
              bus.in_ready <= 1'b0;
            end else if (accept && enc_ok) begin
              bus.in_ready <= (ptr_inc != PTR_MAX);
            end
          end
          SEAL: begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= ptr;
            bus.mem_wdata <= halt_word;
            count         <= count + 1'b1;
            done          <= 1'b1;
            state         <= DONE;
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: default-size loader plus a PC_W=3 instance for the full case.
module tb_instr_encoder_loader;
  logic clk = 1'b0;
  logic reset, start, finish, start3, finish3;
  logic [10:0] count;
  logic [3:0]  count3;
  logic err, done, err3, done3;
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  instr_encoder_loader_if #(.PC_W(10)) b();
  instr_encoder_loader_if #(.PC_W(3))  b3();

  instr_encoder_loader #(.PC_W(10)) dut (
    .clk(clk), .reset(reset), .start(start), .finish(finish),
    .bus(b), .count(count), .err(err), .done(done));

  instr_encoder_loader #(.PC_W(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .finish(finish3),
    .bus(b3), .count(count3), .err(err3), .done(done3));

  task automatic set_beat(input logic [1:0] k, input logic [2:0] s,
                          input logic [3:0] ra, input logic [3:0] rb,
                          input logic [3:0] rd, input logic [7:0] imm,
                          input logic [9:0] a);
    b.in_valid = 1'b1; b.in_kind = k; b.in_sub = s;
    b.in_ra = ra; b.in_rb = rb; b.in_rd = rd; b.in_imm = imm; b.in_addr = a;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 0; finish = 0; start3 = 0; finish3 = 0;
    b.in_valid = 0; b.in_kind = 0; b.in_sub = 0; b.in_ra = 0; b.in_rb = 0;
    b.in_rd = 0; b.in_imm = 0; b.in_addr = 0;
    b3.in_valid = 0; b3.in_kind = 0; b3.in_sub = 0; b3.in_ra = 0; b3.in_rb = 0;
    b3.in_rd = 0; b3.in_imm = 0; b3.in_addr = 0;
    repeat (2) @(negedge clk);
    total++; if (b.in_ready !== 1'b0) $display("FAIL rst_ready: got %0h exp 0", b.in_ready); else passed++;
    total++; if (b.mem_we !== 1'b0) $display("FAIL rst_we: got %0h exp 0", b.mem_we); else passed++;
    total++; if (b.mem_addr !== 10'h0) $display("FAIL rst_addr: got %0h exp 0", b.mem_addr); else passed++;
    total++; if (b.mem_wdata !== 18'h0) $display("FAIL rst_wdata: got %0h exp 0", b.mem_wdata); else passed++;
    total++; if ({count, err, done} !== 13'h0) $display("FAIL rst_cnt_err_done: got %0h exp 0", {count, err, done}); else passed++;
    reset = 1'b0;
    @(negedge clk);
    total++; if (b.in_ready !== 1'b0) $display("FAIL idle_ready: got %0h exp 0", b.in_ready); else passed++;
  endtask

  task automatic test_alu;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++; if (b.in_ready !== 1'b1) $display("FAIL load_ready: got %0h exp 1", b.in_ready); else passed++;
    set_beat(2'd0, 3'b010, 4'd1, 4'd2, 4'd3, 8'h00, 10'h0);
    @(negedge clk); b.in_valid = 1'b0;
    total++; if (b.mem_we !== 1'b1) $display("FAIL alu_we: got %0h exp 1", b.mem_we); else passed++;
    total++; if (b.mem_addr !== 10'h0) $display("FAIL alu_addr: got %0h exp 0", b.mem_addr); else passed++;
    total++; if (b.mem_wdata !== 18'h08123) $display("FAIL alu_word: got %0h exp 08123", b.mem_wdata); else passed++;
    total++; if (count !== 11'd1) $display("FAIL alu_count: got %0d exp 1", count); else passed++;
    @(negedge clk);
    total++; if (b.mem_we !== 1'b0) $display("FAIL alu_we_pulse: got %0h exp 0", b.mem_we); else passed++;
    total++; if (b.mem_wdata !== 18'h08123) $display("FAIL alu_word_hold: got %0h exp 08123", b.mem_wdata); else passed++;
  endtask

  task automatic test_back_to_back;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    set_beat(2'd1, 3'd0, 4'd0, 4'd0, 4'd5, 8'hA7, 10'h0);
    @(negedge clk);
    set_beat(2'd2, 3'd2, 4'd0, 4'd0, 4'd0, 8'h00, 10'h155);
    total++; if ({b.mem_we, b.mem_addr} !== {1'b1, 10'h0}) $display("FAIL b2b_a0: got %0h exp 400", {b.mem_we, b.mem_addr}); else passed++;
    total++; if (b.mem_wdata !== 18'h20A75) $display("FAIL b2b_li: got %0h exp 20a75", b.mem_wdata); else passed++;
    @(negedge clk); b.in_valid = 1'b0;
    total++; if ({b.mem_we, b.mem_addr} !== {1'b1, 10'h1}) $display("FAIL b2b_a1: got %0h exp 401", {b.mem_we, b.mem_addr}); else passed++;
    total++; if (b.mem_wdata !== 18'h3E155) $display("FAIL b2b_jnz: got %0h exp 3e155", b.mem_wdata); else passed++;
    total++; if (count !== 11'd2) $display("FAIL b2b_count: got %0d exp 2", count); else passed++;
  endtask

  task automatic test_illegal;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    set_beat(2'd3, 3'd0, 4'd0, 4'd0, 4'd0, 8'h00, 10'h0);
    @(negedge clk);
    set_beat(2'd2, 3'd3, 4'd0, 4'd0, 4'd0, 8'h00, 10'h3);
    total++; if ({b.mem_we, err} !== 2'b01) $display("FAIL ill_k3: got %0h exp 1", {b.mem_we, err}); else passed++;
    @(negedge clk);
    set_beat(2'd1, 3'd4, 4'd0, 4'd0, 4'd1, 8'h11, 10'h0);
    total++; if ({b.mem_we, err, count} !== {2'b01, 11'd0}) $display("FAIL ill_j3: got %0h exp 800", {b.mem_we, err, count}); else passed++;
    @(negedge clk);
    set_beat(2'd1, 3'd1, 4'd0, 4'd0, 4'd2, 8'h10, 10'h0);
    total++; if ({b.mem_we, count} !== 12'h0) $display("FAIL ill_i4: got %0h exp 0", {b.mem_we, count}); else passed++;
    @(negedge clk); b.in_valid = 1'b0;
    total++; if ({b.mem_we, b.mem_addr} !== {1'b1, 10'h0}) $display("FAIL ill_adi_addr: got %0h exp 400", {b.mem_we, b.mem_addr}); else passed++;
    total++; if (b.mem_wdata !== 18'h24102) $display("FAIL ill_adi_word: got %0h exp 24102", b.mem_wdata); else passed++;
    total++; if (err !== 1'b1) $display("FAIL ill_sticky: got %0h exp 1", err); else passed++;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    total++; if (err !== 1'b0) $display("FAIL ill_clear: got %0h exp 0", err); else passed++;
  endtask

  task automatic test_seal;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_beat(2'd0, 3'd1, 4'(i), 4'd0, 4'd7, 8'h00, 10'h0);
      @(negedge clk);
    end
    b.in_valid = 1'b0; finish = 1'b1;
    total++; if (b.mem_addr !== 10'h2) $display("FAIL seal_last_addr: got %0h exp 2", b.mem_addr); else passed++;
    @(negedge clk); finish = 1'b0;
    total++; if ({b.in_ready, b.mem_we, done} !== 3'b000) $display("FAIL seal_state: got %0h exp 0", {b.in_ready, b.mem_we, done}); else passed++;
    @(negedge clk);
    total++; if ({b.mem_we, b.mem_addr} !== {1'b1, 10'h3}) $display("FAIL seal_halt_addr: got %0h exp 403", {b.mem_we, b.mem_addr}); else passed++;
    total++; if (b.mem_wdata !== 18'h3C003) $display("FAIL seal_halt_word: got %0h exp 3c003", b.mem_wdata); else passed++;
    total++; if ({done, count} !== {1'b1, 11'd4}) $display("FAIL seal_done_count: got %0h exp 804", {done, count}); else passed++;
    @(negedge clk);
    total++; if ({b.in_ready, b.mem_we, done} !== 3'b001) $display("FAIL seal_after: got %0h exp 1", {b.in_ready, b.mem_we, done}); else passed++;
  endtask

  task automatic test_finish_with_beat;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    set_beat(2'd2, 3'd1, 4'd0, 4'd0, 4'd0, 8'h00, 10'h2AA);
    finish = 1'b1;
    @(negedge clk); b.in_valid = 1'b0; finish = 1'b0;
    total++; if ({b.mem_we, b.mem_addr} !== {1'b1, 10'h0}) $display("FAIL fwb_beat_addr: got %0h exp 400", {b.mem_we, b.mem_addr}); else passed++;
    total++; if (b.mem_wdata !== 18'h3D2AA) $display("FAIL fwb_jz_word: got %0h exp 3d2aa", b.mem_wdata); else passed++;
    @(negedge clk);
    total++; if ({b.mem_we, b.mem_addr} !== {1'b1, 10'h1}) $display("FAIL fwb_halt_addr: got %0h exp 401", {b.mem_we, b.mem_addr}); else passed++;
    total++; if (b.mem_wdata !== 18'h3C001) $display("FAIL fwb_halt_word: got %0h exp 3c001", b.mem_wdata); else passed++;
    total++; if (count !== 11'd2) $display("FAIL fwb_count: got %0d exp 2", count); else passed++;
  endtask

  task automatic test_ignored;
    set_beat(2'd0, 3'd5, 4'd9, 4'd9, 4'd9, 8'h00, 10'h0);
    @(negedge clk); b.in_valid = 1'b0;
    total++; if ({b.mem_we, b.in_ready, done, count} !== {3'b001, 11'd2}) $display("FAIL ign_done: got %0h exp 802", {b.mem_we, b.in_ready, done, count}); else passed++;
  endtask

  task automatic test_restart;
    start = 1'b1; finish = 1'b1;
    @(negedge clk); start = 1'b0; finish = 1'b0;
    total++; if ({b.in_ready, done, count} !== {2'b10, 11'd0}) $display("FAIL rs_start_wins: got %0h exp 1000", {b.in_ready, done, count}); else passed++;
    set_beat(2'd0, 3'd0, 4'd0, 4'd0, 4'd1, 8'h00, 10'h0);
    @(negedge clk);
    set_beat(2'd0, 3'd7, 4'd0, 4'd0, 4'd2, 8'h00, 10'h0);
    @(negedge clk); b.in_valid = 1'b0; start = 1'b1;
    total++; if ({b.mem_we, b.mem_addr} !== {1'b1, 10'h1}) $display("FAIL rs_pending: got %0h exp 401", {b.mem_we, b.mem_addr}); else passed++;
    total++; if (b.mem_wdata !== 18'h1C002) $display("FAIL rs_pending_word: got %0h exp 1c002", b.mem_wdata); else passed++;
    @(negedge clk); start = 1'b0;
    total++; if ({b.mem_we, b.in_ready, count} !== {2'b01, 11'd0}) $display("FAIL rs_cleared: got %0h exp 800", {b.mem_we, b.in_ready, count}); else passed++;
    set_beat(2'd1, 3'd0, 4'd0, 4'd0, 4'd5, 8'hA7, 10'h0);
    @(negedge clk); b.in_valid = 1'b0;
    total++; if ({b.mem_we, b.mem_addr, count} !== {1'b1, 10'h0, 11'd1}) $display("FAIL rs_addr0: got %0h exp 200001", {b.mem_we, b.mem_addr, count}); else passed++;
  endtask

  task automatic test_full;
    start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      b3.in_valid = 1'b1; b3.in_kind = 2'd0; b3.in_sub = 3'd3; b3.in_rd = 4'(i);
      @(negedge clk);
      total++; if ({b3.mem_we, b3.mem_addr} !== {1'b1, 3'(i)}) $display("FAIL full_addr%0d: got %0h exp %0h", i, {b3.mem_we, b3.mem_addr}, {1'b1, 3'(i)}); else passed++;
    end
    total++; if ({b3.in_ready, count3} !== {1'b0, 4'd7}) $display("FAIL full_ready: got %0h exp 7", {b3.in_ready, count3}); else passed++;
    @(negedge clk); b3.in_valid = 1'b0; finish3 = 1'b1;
    total++; if ({b3.mem_we, count3} !== {1'b0, 4'd7}) $display("FAIL full_ignored: got %0h exp 7", {b3.mem_we, count3}); else passed++;
    @(negedge clk); finish3 = 1'b0;
    @(negedge clk);
    total++; if ({b3.mem_we, b3.mem_addr} !== {1'b1, 3'd7}) $display("FAIL full_halt_addr: got %0h exp f", {b3.mem_we, b3.mem_addr}); else passed++;
    total++; if (b3.mem_wdata !== 18'h3C007) $display("FAIL full_halt_word: got %0h exp 3c007", b3.mem_wdata); else passed++;
    total++; if ({done3, count3} !== {1'b1, 4'd8}) $display("FAIL full_count: got %0h exp 18", {done3, count3}); else passed++;
  endtask

  task automatic test_reset_mid;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    set_beat(2'd3, 3'd0, 4'd0, 4'd0, 4'd0, 8'h00, 10'h0);
    @(negedge clk);
    set_beat(2'd0, 3'd1, 4'd4, 4'd5, 4'd6, 8'h00, 10'h0);
    @(negedge clk); b.in_valid = 1'b0; reset = 1'b1;
    total++; if ({b.mem_we, err} !== 2'b11) $display("FAIL rm_pre: got %0h exp 3", {b.mem_we, err}); else passed++;
    @(negedge clk); reset = 1'b0;
    total++; if ({b.mem_we, b.in_ready, err, done} !== 4'h0) $display("FAIL rm_flags: got %0h exp 0", {b.mem_we, b.in_ready, err, done}); else passed++;
    total++; if ({b.mem_addr, b.mem_wdata, count} !== 39'h0) $display("FAIL rm_bus: got %0h exp 0", {b.mem_addr, b.mem_wdata, count}); else passed++;
    set_beat(2'd0, 3'd1, 4'd4, 4'd5, 4'd6, 8'h00, 10'h0);
    @(negedge clk); b.in_valid = 1'b0;
    total++; if ({b.mem_we, b.in_ready, count} !== 13'h0) $display("FAIL rm_idle: got %0h exp 0", {b.mem_we, b.in_ready, count}); else passed++;
  endtask

  initial begin
    test_reset;
    test_alu;
    test_back_to_back;
    test_illegal;
    test_seal;
    test_finish_with_beat;
    test_ignored;
    test_restart;
    test_full;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
